ifetch_prefetch: RTL and testbench

Instruction-fetch prefetch engine that sits directly upstream of the prefetch FIFO.
- Issues sequential word-aligned requests on the instruction bus.
- Tracks in-flight requests against the FIFO's free space, so the FIFO is never overrun.
- Writes {error, pc, instr} entries into the FIFO.
- On a jump, flushes the FIFO, redirects the PC and discards responses still in flight from the old stream.

---
 rtl/ifetch_pkg.sv | 14 +
 rtl/ifetch_prefetch_if.sv | 14 +
 rtl/ifetch_inflight_ctr.sv | 47 ++++
 rtl/ifetch_prefetch.sv | 141 ++++++++++++++
 tb/tb_ifetch_prefetch.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and widths for the instruction-fetch prefetch engine.
package ifetch_pkg;
  localparam int C_XLEN        = 32;
  localparam int C_IFIFO_WIDTH = 65;

  // One prefetch FIFO entry; packs to {error[64], pc[63:32], instr[31:0]}.
  typedef struct packed {
    logic              error;
    logic [C_XLEN-1:0] pc;
    logic [C_XLEN-1:0] instr;
  } ifetch_entry_t;

  typedef enum logic {FETCH, HALT} ifetch_state_e;
endpackage

// File: rtl/ifetch_prefetch_if.sv
// Instruction bus: request channel (valid/ready) plus in-order response channel.
interface ifetch_prefetch_if;
  logic                         ireqvalid_o;
  logic                         ireqready_i;
  logic [ifetch_pkg::C_XLEN-1:0] ireqaddr_o;
  logic                         irspvalid_i;
  logic [ifetch_pkg::C_XLEN-1:0] irspdata_i;
  logic                         irsperror_i;

  modport master (output ireqvalid_o, ireqaddr_o,
                  input  ireqready_i, irspvalid_i, irspdata_i, irsperror_i);
  modport slave  (input  ireqvalid_o, ireqaddr_o,
                  output ireqready_i, irspvalid_i, irspdata_i, irsperror_i);
endinterface

// File: rtl/ifetch_inflight_ctr.sv
// Kept/discard in-flight request counters. On a jump every kept request
// becomes a discard, minus whatever retires in the jump cycle itself.
module ifetch_inflight_ctr #(
  parameter int C_OUTSTANDING_X = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     clk_en_i,
  input  logic                     inc_i,          // request accepted
  input  logic                     kept_dec_i,     // kept response written to FIFO
  input  logic                     disc_dec_i,     // stale response dropped
  input  logic                     jump_i,         // qualified jump
  input  logic [1:0]               jump_retire_i,  // items leaving the in-flight set in the jump cycle
  output logic [C_OUTSTANDING_X:0] kept_o,
  output logic [C_OUTSTANDING_X:0] discard_o
);
  localparam int W = C_OUTSTANDING_X + 1;

  logic [W-1:0] kept_q, kept_d, discard_q, discard_d;

  // Next-count: jump moves kept into discard, else count up/down independently.
  always_comb begin
    kept_d    = kept_q;
    discard_d = discard_q;
    if (jump_i) begin
      kept_d    = '0;
      discard_d = discard_q + kept_q - W'(jump_retire_i);
    end else begin
      kept_d    = kept_q + W'(inc_i) - W'(kept_dec_i);
      discard_d = discard_q - W'(disc_dec_i);
    end
  end

  // Counter registers, frozen while the clock enable is low.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      kept_q    <= '0;
      discard_q <= '0;
    end else if (clk_en_i) begin
      kept_q    <= kept_d;
      discard_q <= discard_d;
    end
  end

  assign kept_o    = kept_q;
  assign discard_o = discard_q;
endmodule

// File: rtl/ifetch_prefetch.sv
// Sequential instruction prefetcher feeding the prefetch FIFO.
// Optional build macro IFETCH_RSP_REG_EN: registers each kept response for
// one cycle before it is written to the FIFO.
module ifetch_prefetch
  import ifetch_pkg::*;
#(
  parameter int          C_FIFO_DEPTH_X  = 2,
  parameter int          C_OUTSTANDING_X = 2,
  parameter logic [31:0] C_RESET_VECTOR  = 32'h0000_0000
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     clk_en_i,
  input  logic                     jump_i,
  input  logic [C_XLEN-1:0]        jump_addr_i,
  ifetch_prefetch_if.master        bus,
  input  logic                     fifo_rd_i,
  output logic                     fifo_wr_o,
  output logic [C_IFIFO_WIDTH-1:0] fifo_din_o,
  output logic                     fifo_flush_o
);
  localparam int LW = C_FIFO_DEPTH_X + 1;
  localparam int KW = C_OUTSTANDING_X + 1;

  ifetch_state_e     state_q, state_d;
  logic [C_XLEN-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d, jump_pc;
  logic [LW-1:0]     level_q, level_d;
  logic [KW-1:0]     kept, discard;
  logic              room, accept, rsp_take, rsp_keep, rsp_drop, wr, jump_en;
  logic [1:0]        jump_retire;
  ifetch_entry_t     rsp_entry, wr_entry;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^jump_addr_i[1:0];
  assign jump_pc         = {jump_addr_i[C_XLEN-1:2], 2'b00};
  assign jump_en         = jump_i & clk_en_i;

  // Never have more in the FIFO plus in flight than the FIFO can hold.
  assign room = (32'(level_q) + 32'(kept)    < (32'd1 << C_FIFO_DEPTH_X)) &&
                (32'(kept)    + 32'(discard) < (32'd1 << C_OUTSTANDING_X));

  assign bus.ireqvalid_o = ~reset_i & (state_q == FETCH) & ~jump_i & room;
  assign bus.ireqaddr_o  = reset_i ? C_RESET_VECTOR : pc_q;
  assign accept          = bus.ireqvalid_o & bus.ireqready_i & clk_en_i;

  // A response in the jump cycle always belongs to the old stream.
  assign rsp_take  = bus.irspvalid_i & clk_en_i & ~jump_i & ~reset_i;
  assign rsp_keep  = rsp_take & (discard == '0);
  assign rsp_drop  = rsp_take & (discard != '0);
  assign rsp_entry = '{error: bus.irsperror_i, pc: rsp_pc_q, instr: bus.irspdata_i};

`ifdef IFETCH_RSP_REG_EN
  logic          slot_vld_q, slot_vld_d;
  ifetch_entry_t slot_q, slot_d;

  // Response slot: a jump kills it, otherwise drain it and refill from the bus.
  always_comb begin
    slot_vld_d = slot_vld_q;
    slot_d     = slot_q;
    if (jump_en) begin
      slot_vld_d = 1'b0;
    end else begin
      if (wr)       slot_vld_d = 1'b0;
      if (rsp_keep) begin
        slot_vld_d = 1'b1;
        slot_d     = rsp_entry;
      end
    end
  end

  // Response slot registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      slot_vld_q <= 1'b0;
      slot_q     <= '0;
    end else if (clk_en_i) begin
      slot_vld_q <= slot_vld_d;
      slot_q     <= slot_d;
    end
  end

  assign wr          = slot_vld_q & clk_en_i & ~jump_i & ~reset_i;
  assign wr_entry    = slot_q;
  assign jump_retire = {1'b0, bus.irspvalid_i} + {1'b0, slot_vld_q};
`else
  assign wr          = rsp_keep;
  assign wr_entry    = rsp_entry;
  assign jump_retire = {1'b0, bus.irspvalid_i};
`endif

  assign fifo_wr_o    = wr;
  assign fifo_din_o   = wr_entry;
  assign fifo_flush_o = jump_i & ~reset_i;

  ifetch_inflight_ctr #(.C_OUTSTANDING_X(C_OUTSTANDING_X)) u_ctr (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .clk_en_i      (clk_en_i),
    .inc_i         (accept),
    .kept_dec_i    (wr),
    .disc_dec_i    (rsp_drop),
    .jump_i        (jump_en),
    .jump_retire_i (jump_retire),
    .kept_o        (kept),
    .discard_o     (discard)
  );

  // Next PC / occupancy / state; a jump redirects both PCs and empties the FIFO.
  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    level_d  = level_q;
    state_d  = state_q;
    if (jump_i) begin
      pc_d     = jump_pc;
      rsp_pc_d = jump_pc;
      level_d  = '0;
      state_d  = FETCH;
    end else begin
      if (accept)   pc_d     = pc_q + 32'd4;
      if (rsp_keep) rsp_pc_d = rsp_pc_q + 32'd4;
      level_d = level_q + LW'(wr) - LW'(fifo_rd_i && (level_q != '0));
      if (wr && wr_entry.error) state_d = HALT;
    end
  end

  // Main state registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= FETCH;
      pc_q     <= C_RESET_VECTOR;
      rsp_pc_q <= C_RESET_VECTOR;
      level_q  <= '0;
    end else if (clk_en_i) begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      level_q  <= level_d;
    end
  end
endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench: in-order bus responder with 1-cycle latency, request and
// FIFO-write logs, checked against hand-computed sequences.
module tb_ifetch_prefetch;
  logic        clk = 1'b0;
  logic        reset_i, clk_en_i, jump_i, fifo_rd_i;
  logic [31:0] jump_addr_i;
  logic        fifo_wr_o, fifo_flush_o;
  logic [64:0] fifo_din_o;

  ifetch_prefetch_if bus();

  ifetch_prefetch dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .clk_en_i     (clk_en_i),
    .jump_i       (jump_i),
    .jump_addr_i  (jump_addr_i),
    .bus          (bus),
    .fifo_rd_i    (fifo_rd_i),
    .fifo_wr_o    (fifo_wr_o),
    .fifo_din_o   (fifo_din_o),
    .fifo_flush_o (fifo_flush_o)
  );

  always #5 clk = ~clk;

  int          errs = 0, checks = 0;
  logic [31:0] req_q[$];
  logic [64:0] wr_q[$];
  logic [31:0] pend_q[$];
  logic        rsp_hold = 1'b0, err_en = 1'b0;
  logic [31:0] err_addr = 32'h0;
  logic        last_vld, last_wr, last_flush;
  logic [31:0] last_addr;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [64:0] ent(input logic e, input logic [31:0] pc);
    return {e, pc, instr_of(pc)};
  endfunction

  function automatic logic [31:0] req_at(input int i);
    return (i < req_q.size()) ? req_q[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [64:0] wr_at(input int i);
    return (i < wr_q.size()) ? wr_q[i] : 65'hx;
  endfunction

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_rsp();
    if (!rsp_hold && pend_q.size() > 0) begin
      bus.irspvalid_i = 1'b1;
      bus.irspdata_i  = instr_of(pend_q[0]);
      bus.irsperror_i = err_en && (pend_q[0] == err_addr);
    end else begin
      bus.irspvalid_i = 1'b0;
      bus.irspdata_i  = 32'h0;
      bus.irsperror_i = 1'b0;
    end
  endtask

  // One clock: observe at negedge, advance responder after posedge.
  task automatic cyc();
    logic acc, taken;
    logic [31:0] a;
    @(negedge clk);
    acc   = bus.ireqvalid_o & bus.ireqready_i & clk_en_i & ~reset_i;
    a     = bus.ireqaddr_o;
    taken = bus.irspvalid_i & clk_en_i;
    if (acc) req_q.push_back(a);
    if (fifo_wr_o) wr_q.push_back(fifo_din_o);
    last_vld = bus.ireqvalid_o; last_wr = fifo_wr_o;
    last_flush = fifo_flush_o;  last_addr = a;
    @(posedge clk); #1;
    if (reset_i) pend_q.delete();
    else begin
      if (taken) void'(pend_q.pop_front());
      if (acc) pend_q.push_back(a);
    end
    jump_i = 1'b0; fifo_rd_i = 1'b0;
    drive_rsp();
  endtask

  task automatic clr();
    req_q.delete(); wr_q.delete();
  endtask

  initial begin
    reset_i = 1'b1; clk_en_i = 1'b1; jump_i = 1'b0; fifo_rd_i = 1'b0;
    jump_addr_i = 32'h0; bus.ireqready_i = 1'b1;
    drive_rsp();

    // Reset state
    cyc();
    chk("rst_vld", last_vld, 0);
    chk("rst_wr", last_wr, 0);
    chk("rst_flush", last_flush, 0);
    chk("rst_addr", last_addr, 32'h0);
    cyc();
    reset_i = 1'b0; clr();

    // Fill: four requests, four writes, then stall on FIFO full
    repeat (10) cyc();
    chk("fill_nreq", req_q.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("fill_req%0d", i), req_at(i), 32'(i*4));
    chk("fill_nwr", wr_q.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("fill_wr%0d", i), wr_at(i), ent(1'b0, 32'(i*4)));
    chk("fill_vld_low", last_vld, 0);

    // One pop releases exactly one request
    clr(); fifo_rd_i = 1'b1; cyc();
    repeat (6) cyc();
    chk("pop_nreq", req_q.size(), 1);
    chk("pop_req", req_at(0), 32'h10);
    chk("pop_wr", wr_at(0), ent(1'b0, 32'h10));

    // Three in flight (responses held), then jump
    clr(); rsp_hold = 1'b1; drive_rsp();
    repeat (3) begin fifo_rd_i = 1'b1; cyc(); end
    repeat (3) cyc();
    chk("infl_nreq", req_q.size(), 3);
    chk("infl_req0", req_at(0), 32'h14);
    chk("infl_req2", req_at(2), 32'h1C);
    clr(); rsp_hold = 1'b0; drive_rsp();
    jump_i = 1'b1; jump_addr_i = 32'h0000_1003; cyc();
    chk("jmp_flush", last_flush, 1);
    chk("jmp_wr", last_wr, 0);
    chk("jmp_vld", last_vld, 0);
    repeat (14) cyc();
    chk("jmp_req0", req_at(0), 32'h1000);
    chk("jmp_nreq", req_q.size(), 4);
    chk("jmp_nwr", wr_q.size(), 4);
    chk("jmp_wr0", wr_at(0), ent(1'b0, 32'h1000));
    chk("jmp_wr3", wr_at(3), ent(1'b0, 32'h100C));

    // Bus error at pc 0x8 halts fetching until the next jump
    clr(); err_en = 1'b1; err_addr = 32'h8;
    jump_i = 1'b1; jump_addr_i = 32'h0; cyc();
    repeat (8) cyc();
    chk("err_nwr", wr_q.size(), 4);
    chk("err_wr1", wr_at(1), ent(1'b0, 32'h4));
    chk("err_wr2", wr_at(2), ent(1'b1, 32'h8));
    clr();
    repeat (4) begin fifo_rd_i = 1'b1; cyc(); end
    repeat (4) cyc();
    chk("halt_nreq", req_q.size(), 0);
    chk("halt_vld", last_vld, 0);
    err_en = 1'b0;
    jump_i = 1'b1; jump_addr_i = 32'h2000; cyc();
    repeat (8) cyc();
    chk("resume_req0", req_at(0), 32'h2000);
    chk("resume_nreq", req_q.size(), 4);

    // PC wrap at the top of the address space
    clr(); jump_i = 1'b1; jump_addr_i = 32'hFFFF_FFF8; cyc();
    repeat (8) cyc();
    chk("wrap_req0", req_at(0), 32'hFFFF_FFF8);
    chk("wrap_req1", req_at(1), 32'hFFFF_FFFC);
    chk("wrap_req2", req_at(2), 32'h0000_0000);
    chk("wrap_wr2", wr_at(2), ent(1'b0, 32'h0));

    // Clock enable low for 5 cycles with a response pending
    clr(); jump_i = 1'b1; jump_addr_i = 32'h3000; cyc();
    repeat (2) cyc();
    clr(); clk_en_i = 1'b0;
    repeat (5) cyc();
    chk("cen_nwr", wr_q.size(), 0);
    chk("cen_nreq", req_q.size(), 0);
    chk("cen_addr", last_addr, 32'h3008);
    clk_en_i = 1'b1;
    repeat (3) cyc();
    chk("cen_wr0", wr_at(0), ent(1'b0, 32'h3004));
    chk("cen_req0", req_at(0), 32'h3008);

    // Reset mid-burst
    reset_i = 1'b1; cyc();
    chk("mrst_vld", last_vld, 0);
    chk("mrst_addr", last_addr, 32'h0);
    reset_i = 1'b0; clr();
    repeat (10) cyc();
    chk("mrst_req0", req_at(0), 32'h0);
    chk("mrst_nreq", req_q.size(), 4);
    chk("mrst_wr0", wr_at(0), ent(1'b0, 32'h0));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
